// File: rtl/div_result_buffer_if.sv
// Handshake and payload bundle between a divider array, the result buffer and its consumer.
interface div_result_buffer_if #(
    parameter int unsigned CNT_W = 8
);
    // upstream side: operands and divider-array result
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       n_in;
    logic [3:0]       d_in;
    logic [3:0]       q_in;
    logic [3:0]       r_in;
    // downstream side: head entry
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_q;
    logic [3:0]       out_r;
    logic             out_dz;
    logic             out_err;
    // statistics
    logic [CNT_W-1:0] res_count;
    logic [CNT_W-1:0] err_count;

    // producer/consumer environment around the buffer
    modport master (
        output in_valid, n_in, d_in, q_in, r_in, out_ready,
        input  in_ready, out_valid, out_q, out_r, out_dz, out_err, res_count, err_count
    );

    // the buffer itself
    modport slave (
        input  in_valid, n_in, d_in, q_in, r_in, out_ready,
        output in_ready, out_valid, out_q, out_r, out_dz, out_err, res_count, err_count
    );
endinterface

// File: rtl/div_result_buffer.sv
// Two-entry in-order buffer for 4-bit divider results with divide-by-zero
// substitution, consistency checking and saturating statistics counters.
module div_result_buffer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    div_result_buffer_if.slave bus
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned OCC_W = 2;
    localparam int unsigned SUM_W = 9;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        logic       err;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    entry_t             head_q, head_d;
    entry_t             in_entry;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]   res_count_q, res_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [SUM_W-1:0]   chk_sum;
    logic               in_ready_c, out_valid_c;
    logic               push, pop;

    assign in_ready_c  = (occ_q != OCC_W'(DEPTH)) && !rst;
    assign out_valid_c = (occ_q != '0) && !rst;
    assign push        = bus.in_valid && in_ready_c;
    assign pop         = out_valid_c && bus.out_ready;

    // Build the entry to store: substitute on divide-by-zero, otherwise verify q*d+r == n and r < d.
    always_comb begin
        in_entry = '0;
        chk_sum  = SUM_W'(bus.q_in) * SUM_W'(bus.d_in) + SUM_W'(bus.r_in);
        if (bus.d_in == 4'd0) begin
            in_entry.q  = 4'hF;
            in_entry.r  = bus.n_in;
            in_entry.dz = 1'b1;
        end else begin
            in_entry.q   = bus.q_in;
            in_entry.r   = bus.r_in;
            in_entry.err = (chk_sum != SUM_W'(bus.n_in)) || (bus.r_in >= bus.d_in);
        end
    end

    // Next-state for storage, pointers, occupancy, head output and counters.
    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        occ_d       = occ_q;
        res_count_d = res_count_q;
        err_count_d = err_count_q;
        head_d      = '0;

        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = ~wr_ptr_q;
            if (res_count_q != '1) begin
                res_count_d = res_count_q + CNT_W'(1);
            end
            if ((in_entry.dz || in_entry.err) && (err_count_q != '1)) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // head register mirrors the entry that will sit at the read pointer next cycle
        if (occ_d != '0) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    // State registers with synchronous reset that flushes all contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            occ_q       <= '0;
            head_q      <= '0;
            res_count_q <= '0;
            err_count_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            res_count_q <= res_count_d;
            err_count_q <= err_count_d;
        end
    end

    // Entry storage; contents are meaningless while the occupancy excludes them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head data is zero whenever no entry is presented, including while reset is held.
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_q     = rst ? 4'd0 : head_q.q;
    assign bus.out_r     = rst ? 4'd0 : head_q.r;
    assign bus.out_dz    = rst ? 1'b0 : head_q.dz;
    assign bus.out_err   = rst ? 1'b0 : head_q.err;
    assign bus.res_count = res_count_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_div_result_buffer.sv
// Scoreboard bench for div_result_buffer: directed scenarios followed by random traffic.
module tb_div_result_buffer;

    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int q;
        int r;
        int dz;
        int err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_result_buffer_if #(.CNT_W(CNT_W)) bus ();

    div_result_buffer #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   m_occ  = 0;
    int   m_res  = 0;
    int   m_err  = 0;
    bit   done   = 1'b0;

    // Reference result for one operand set, straight from the arithmetic definition.
    function automatic exp_t ref_result(int n, int d, int q, int r);
        exp_t e;
        if (d == 0) begin
            e.q = 15; e.r = n; e.dz = 1; e.err = 0;
        end else begin
            e.q = q; e.r = r; e.dz = 0;
            e.err = ((q * d + r) != n || r >= d) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Predictor: advance the model at each edge using the inputs the DUT samples there.
    always @(posedge clk) begin
        bit push, pop;
        if (rst) begin
            sb.delete();
            m_occ = 0;
            m_res = 0;
            m_err = 0;
        end else begin
            push = bus.in_valid && (m_occ < 2);
            pop  = (m_occ > 0) && bus.out_ready;
            if (pop) m_occ--;
            if (push) begin
                exp_t e;
                e = ref_result(int'(bus.n_in), int'(bus.d_in), int'(bus.q_in), int'(bus.r_in));
                sb.push_back(e);
                m_occ++;
                if (m_res < CNT_MAX) m_res++;
                if ((e.dz != 0 || e.err != 0) && m_err < CNT_MAX) m_err++;
            end
        end
    end

    // Monitor: mid-cycle, compare flags and counters, and pop the scoreboard on each delivery.
    always @(negedge clk) begin
        if (!done) begin
            check("in_ready",  16'(bus.in_ready),  16'((!rst && m_occ < 2) ? 1 : 0));
            check("out_valid", 16'(bus.out_valid), 16'((!rst && m_occ > 0) ? 1 : 0));
            check("res_count", 16'(bus.res_count), 16'(m_res));
            check("err_count", 16'(bus.err_count), 16'(m_err));
            if (!bus.out_valid) begin
                check("idle_data", 16'({bus.out_q, bus.out_r, bus.out_dz, bus.out_err}), 16'(0));
            end else if (bus.out_ready && !rst) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_delivery at %0t: got q=%0h r=%0h expected no entry",
                             $time, bus.out_q, bus.out_r);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_q",   16'(bus.out_q),   16'(e.q));
                    check("out_r",   16'(bus.out_r),   16'(e.r));
                    check("out_dz",  16'(bus.out_dz),  16'(e.dz));
                    check("out_err", 16'(bus.out_err), 16'(e.err));
                end
            end
        end
    end

    task automatic drive(bit v, int n, int d, int q, int r, bit ordy);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.n_in      = 4'(n);
        bus.d_in      = 4'(d);
        bus.q_in      = 4'(q);
        bus.r_in      = 4'(r);
        bus.out_ready = ordy;
    endtask

    task automatic idle(int cycles, bit ordy);
        for (int i = 0; i < cycles; i++) drive(1'b0, 0, 0, 0, 0, ordy);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.n_in      = '0;
        bus.d_in      = '0;
        bus.q_in      = '0;
        bus.r_in      = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        idle(2, 1'b0);
        @(posedge clk); #1; rst = 1'b0;

        // correct result, divide-by-zero, and both kinds of inconsistency
        drive(1'b1, 13, 3, 4, 1, 1'b1);
        idle(2, 1'b1);
        drive(1'b1, 9, 0, 7, 2, 1'b1);
        idle(2, 1'b1);
        drive(1'b1, 12, 2, 2, 0, 1'b1);
        drive(1'b1, 7, 2, 2, 3, 1'b1);
        idle(2, 1'b1);

        // fill while stalled: third push must be refused, then drain
        drive(1'b1, 10, 5, 2, 0, 1'b0);
        drive(1'b1, 11, 4, 2, 3, 1'b0);
        drive(1'b1, 6, 3, 2, 0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // simultaneous push/pop at occupancy 1, then pop with in_valid high at occupancy 2
        drive(1'b1, 8, 2, 4, 0, 1'b0);
        drive(1'b1, 15, 4, 3, 3, 1'b1);
        drive(1'b1, 14, 7, 2, 0, 1'b0);
        drive(1'b1, 5, 5, 1, 0, 1'b1);
        idle(3, 1'b1);

        // reset mid-operation with a full buffer and nonzero counters
        drive(1'b1, 3, 1, 3, 0, 1'b0);
        drive(1'b1, 4, 0, 0, 0, 1'b0);
        idle(1, 1'b0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        idle(2, 1'b1);

        // random traffic, long enough to saturate res_count
        for (int i = 0; i < 1500; i++) begin
            int n, d, q, r;
            n = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 15));
            if (d != 0 && $urandom_range(0, 3) != 0) begin
                q = n / d;
                r = n % d;
            end else begin
                q = int'($urandom_range(0, 15));
                r = int'($urandom_range(0, 15));
            end
            drive($urandom_range(0, 3) != 0, n, d, q, r, $urandom_range(0, 2) != 0);
        end
        idle(4, 1'b1);

        @(negedge clk);
        done = 1'b1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
